hart_regfile: RTL

- Per-hart architectural state store for the barrel pipeline: one PC and 31 GPRs (x1..x31) for each of NUM_HART harts. x0 is hardwired to zero.
- Serves the pipeline's PC read (fetch stage), GPR reads (decode stage), PC write (memrw stage) and GPR write (regwr stage).
- After reset it runs an init sweep that zeroes the GPR storage, then asserts ready. The pipeline is held in reset until ready is high.

---
 rtl/hart_regfile.sv | 113 +++++++++++
 1 files changed

// File: rtl/hart_regfile.sv
// hart_regfile: per-hart PC and x1..x31 GPR storage for a barrel pipeline, with a post-reset zeroing sweep.
module hart_regfile #(
  parameter int NUM_HART = 4,
  parameter int REG_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [NUM_HART-1:0]  pc_rd_hart_sel,
  output logic [REG_WIDTH-1:0] pc,
  input  logic [NUM_HART-1:0]  reg_rd_hart_sel,
  input  logic [4:0]           reg1_rd_addr,
  input  logic [4:0]           reg2_rd_addr,
  output logic [REG_WIDTH-1:0] reg1,
  output logic [REG_WIDTH-1:0] reg2,
  input  logic [NUM_HART-1:0]  pc_wr_hart_sel,
  input  logic                 pc_wr_en,
  input  logic [REG_WIDTH-1:0] pc_wr_data,
  input  logic [NUM_HART-1:0]  reg_wr_hart_sel,
  input  logic                 reg_wr_en,
  input  logic [4:0]           reg_wr_addr,
  input  logic [REG_WIDTH-1:0] reg_wr_data
);
  localparam int HW = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [REG_WIDTH-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [REG_WIDTH-1:0] pc_q [NUM_HART];
  logic [REG_WIDTH-1:0] pc_d [NUM_HART];
  logic [REG_WIDTH-1:0] gpr_mem [NUM_HART][1:31];
  logic [NUM_HART-1:0]  gpr_we;
  logic [4:0]           gpr_wa;
  logic [REG_WIDTH-1:0] gpr_wd;
  logic [HW-1:0]        pc_hart, rd_hart;
  logic                 in_ready, hit1, hit2;

  function automatic logic [HW-1:0] lowest(input logic [NUM_HART-1:0] sel);
    lowest = '0;
    for (int i = NUM_HART - 1; i >= 0; i--)
      if (sel[i]) lowest = HW'(i);
  endfunction

  assign in_ready = state_q == S_READY;
  assign pc_hart  = lowest(pc_rd_hart_sel);
  assign rd_hart  = lowest(reg_rd_hart_sel);
  assign pc       = |pc_rd_hart_sel ? pc_q[pc_hart] : '0;
  assign ready    = ready_q;
  assign reg1     = reg1_q;
  assign reg2     = reg2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    pc_d    = pc_q;
    gpr_we  = '0;
    gpr_wa  = reg_wr_addr;
    gpr_wd  = reg_wr_data;
    if (state_q == S_RESET) begin
      state_d = S_INIT;
    end else if (state_q == S_INIT) begin
      // sweep zeroes one register index across all harts per cycle
      gpr_we = '1;
      gpr_wa = cnt_q;
      gpr_wd = '0;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = S_READY;
        ready_d = 1'b1;
      end
    end else begin
      gpr_we = (reg_wr_en && reg_wr_addr != 5'd0) ? reg_wr_hart_sel : '0;
      for (int i = 0; i < NUM_HART; i++)
        if (pc_wr_en && pc_wr_hart_sel[i]) pc_d[i] = pc_wr_data;
    end
    // same-cycle write to the read hart/address is forwarded into the read register
    hit1 = reg_wr_en && reg_wr_hart_sel[rd_hart] && reg_wr_addr == reg1_rd_addr;
    hit2 = reg_wr_en && reg_wr_hart_sel[rd_hart] && reg_wr_addr == reg2_rd_addr;
    reg1_d = (!in_ready || reg1_rd_addr == 5'd0 || reg_rd_hart_sel == '0) ? '0 :
             hit1 ? reg_wr_data : gpr_mem[rd_hart][reg1_rd_addr];
    reg2_d = (!in_ready || reg2_rd_addr == 5'd0 || reg_rd_hart_sel == '0) ? '0 :
             hit2 ? reg_wr_data : gpr_mem[rd_hart][reg2_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RESET;
      cnt_q   <= 5'd1;
      ready_q <= 1'b0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      for (int i = 0; i < NUM_HART; i++) pc_q[i] <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_HART; i++)
      if (gpr_we[i]) gpr_mem[i][gpr_wa] <= gpr_wd;
  end
endmodule
